// File: rtl/sram_arbiter.sv
// Two-master sram-like arbiter: merges the IF and MEM-stage ports onto one downstream port
// and routes in-order responses back using an owner FIFO of outstanding transactions.
module sram_arbiter #(
    parameter int DEPTH  = 4,
    parameter int STARVE = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE);

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    logic [DEPTH-1:0] owner_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             lock_q;
    logic             lock_owner_q;
    logic [SW-1:0]    starve_q;

    logic grant;
    logic grant_req;
    logic accept;
    logic pop;
    logic head_owner;

    // NOTE: every branch assigns grant, so no latch is inferred.
    always_comb begin
        if (lock_q)
            grant = lock_owner_q;
        else if (inst_sram_req && starve_q == STARVE_C)
            grant = GRANT_INST;
        else if (data_sram_req)
            grant = GRANT_DATA;
        else
            grant = GRANT_INST;
    end

    assign grant_req = (grant == GRANT_DATA) ? data_sram_req : inst_sram_req;
    // Gating with resetn keeps the handshake outputs low during reset, not one cycle later.
    assign mem_req   = resetn & grant_req & (count < DEPTH_C);

    assign mem_wr    = (grant == GRANT_DATA) ? data_sram_wr    : 1'b0;
    assign mem_size  = (grant == GRANT_DATA) ? data_sram_size  : 2'd2;
    assign mem_wstrb = (grant == GRANT_DATA) ? data_sram_wstrb : 4'd0;
    assign mem_addr  = (grant == GRANT_DATA) ? data_sram_addr  : inst_sram_addr;
    assign mem_wdata = (grant == GRANT_DATA) ? data_sram_wdata : 32'd0;

    assign accept            = mem_req & mem_addr_ok;
    assign inst_sram_addr_ok = accept & (grant == GRANT_INST);
    assign data_sram_addr_ok = accept & (grant == GRANT_DATA);

    assign head_owner        = owner_q[rd_ptr];
    assign pop               = resetn & mem_data_ok & (count != '0);
    assign inst_sram_data_ok = pop & (head_owner == GRANT_INST);
    assign data_sram_data_ok = pop & (head_owner == GRANT_DATA);
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= GRANT_INST;
            starve_q     <= '0;
        end else begin
            lock_q       <= mem_req & ~mem_addr_ok;
            lock_owner_q <= grant;

            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (!inst_sram_req || (accept && grant == GRANT_INST))
                starve_q <= '0;
            else if (accept && grant == GRANT_DATA && starve_q != STARVE_C)
                starve_q <= starve_q + 1'b1;
        end
    end

    // NOTE: owner storage has no reset; entries are only read below count, which is reset.
    always_ff @(posedge clk) begin
        if (accept)
            owner_q[wr_ptr] <= grant;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter: priority, lock, starvation, ordering,
// full/empty boundaries and asynchronous reset.
module tb_sram_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    sram_arbiter dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_req           (mem_req),
        .mem_wr            (mem_wr),
        .mem_size          (mem_size),
        .mem_wstrb         (mem_wstrb),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_addr_ok       (mem_addr_ok),
        .mem_data_ok       (mem_data_ok),
        .mem_rdata         (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        inst_sram_req   = 1'b0;
        inst_sram_addr  = 32'h0000_0200;
        data_sram_req   = 1'b0;
        data_sram_wr    = 1'b1;
        data_sram_size  = 2'd0;
        data_sram_wstrb = 4'hf;
        data_sram_addr  = 32'h0000_0100;
        data_sram_wdata = 32'hdead_beef;
        mem_addr_ok     = 1'b0;
        mem_data_ok     = 1'b0;
        mem_rdata       = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        tick();

        // Outputs held low during reset even with active requests.
        inst_sram_req = 1'b1;
        data_sram_req = 1'b1;
        mem_addr_ok   = 1'b1;
        mem_data_ok   = 1'b1;
        settle();
        check("rst_mem_req",      mem_req,           0);
        check("rst_inst_addr_ok", inst_sram_addr_ok, 0);
        check("rst_data_addr_ok", data_sram_addr_ok, 0);
        check("rst_data_data_ok", data_sram_data_ok, 0);

        // Both requesters, downstream ready: data wins.
        do_reset();
        inst_sram_req = 1'b1;
        data_sram_req = 1'b1;
        mem_addr_ok   = 1'b1;
        settle();
        check("prio_mem_req",      mem_req,           1);
        check("prio_data_addr_ok", data_sram_addr_ok, 1);
        check("prio_inst_addr_ok", inst_sram_addr_ok, 0);
        check("prio_mem_addr",     mem_addr,          32'h0000_0100);
        check("prio_mem_wdata",    mem_wdata,         32'hdead_beef);

        // Data stalled, inst request arrives: grant and address stay on data.
        do_reset();
        data_sram_req = 1'b1;
        settle();
        check("lockd_mem_req",  mem_req,  1);
        check("lockd_addr_0",   mem_addr, 32'h0000_0100);
        tick();
        inst_sram_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("lockd_addr_hold", mem_addr,          32'h0000_0100);
            check("lockd_no_iok",    inst_sram_addr_ok, 0);
            tick();
        end
        mem_addr_ok = 1'b1;
        settle();
        check("lockd_accept",  data_sram_addr_ok, 1);
        check("lockd_inst_no", inst_sram_addr_ok, 0);
        tick();
        data_sram_req = 1'b0;
        settle();
        check("lockd_inst_next", inst_sram_addr_ok, 1);
        tick();

        // Inst stalled, data request arrives: lock keeps inst on the bus.
        mem_addr_ok = 1'b0;
        settle();
        check("locki_addr_0", mem_addr, 32'h0000_0200);
        tick();
        data_sram_req = 1'b1;
        settle();
        check("locki_addr_hold", mem_addr, 32'h0000_0200);
        check("locki_wr",        mem_wr,   0);
        mem_addr_ok = 1'b1;
        settle();
        check("locki_inst_ok", inst_sram_addr_ok, 1);
        check("locki_data_no", data_sram_addr_ok, 0);
        tick();

        // Starvation: with continuous pops, pattern D D D D I repeats; inst fields forced.
        do_reset();
        inst_sram_req = 1'b1;
        data_sram_req = 1'b1;
        mem_addr_ok   = 1'b1;
        mem_data_ok   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            check("starve_data_ok", data_sram_addr_ok, (i % 5 == 4) ? 0 : 1);
            check("starve_inst_ok", inst_sram_addr_ok, (i % 5 == 4) ? 1 : 0);
            if (i == 4) begin
                check("inst_wr",    mem_wr,    0);
                check("inst_size",  mem_size,  2);
                check("inst_wstrb", mem_wstrb, 0);
                check("inst_wdata", mem_wdata, 0);
                check("inst_addr",  mem_addr,  32'h0000_0200);
            end
            tick();
        end

        // In-order response routing: inst, data, inst.
        do_reset();
        mem_addr_ok   = 1'b1;
        inst_sram_req = 1'b1;
        tick();
        inst_sram_req = 1'b0;
        data_sram_req = 1'b1;
        tick();
        data_sram_req = 1'b0;
        inst_sram_req = 1'b1;
        tick();
        inst_sram_req = 1'b0;
        mem_data_ok   = 1'b1;
        mem_rdata     = 32'h11;
        settle();
        check("order1_inst_ok", inst_sram_data_ok, 1);
        check("order1_data_ok", data_sram_data_ok, 0);
        check("order1_rdata",   inst_sram_rdata,   32'h11);
        tick();
        mem_rdata = 32'h22;
        settle();
        check("order2_inst_ok", inst_sram_data_ok, 0);
        check("order2_data_ok", data_sram_data_ok, 1);
        check("order2_rdata",   data_sram_rdata,   32'h22);
        tick();
        mem_rdata = 32'h33;
        settle();
        check("order3_inst_ok", inst_sram_data_ok, 1);
        check("order3_data_ok", data_sram_data_ok, 0);
        check("order3_rdata",   inst_sram_rdata,   32'h33);
        tick();

        // Full and empty boundaries (DEPTH = 4).
        do_reset();
        data_sram_req = 1'b1;
        mem_addr_ok   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("fill_accept", data_sram_addr_ok, 1);
            tick();
        end
        settle();
        check("full_mem_req", mem_req,           0);
        check("full_addr_ok", data_sram_addr_ok, 0);
        mem_data_ok = 1'b1;
        settle();
        check("full_pop_mem_req", mem_req,           0);
        check("full_pop_data_ok", data_sram_data_ok, 1);
        tick();
        mem_data_ok = 1'b0;
        settle();
        check("after_pop_req",    mem_req,           1);
        check("after_pop_accept", data_sram_addr_ok, 1);
        tick();
        data_sram_req = 1'b0;
        mem_data_ok   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("drain_data_ok", data_sram_data_ok, 1);
            tick();
        end
        settle();
        check("empty_data_ok", data_sram_data_ok, 0);
        check("empty_inst_ok", inst_sram_data_ok, 0);
        tick();
        mem_data_ok = 1'b0;

        // Asynchronous reset with two outstanding transactions.
        do_reset();
        mem_addr_ok   = 1'b1;
        inst_sram_req = 1'b1;
        tick();
        inst_sram_req = 1'b0;
        data_sram_req = 1'b1;
        tick();
        data_sram_req = 1'b0;
        inst_sram_req = 1'b1;
        mem_data_ok   = 1'b1;
        #2;
        resetn = 1'b0;
        settle();
        check("arst_mem_req",      mem_req,           0);
        check("arst_inst_addr_ok", inst_sram_addr_ok, 0);
        check("arst_inst_data_ok", inst_sram_data_ok, 0);
        check("arst_data_data_ok", data_sram_data_ok, 0);
        tick();
        inst_sram_req = 1'b0;
        resetn        = 1'b1;
        settle();
        check("arst_post_inst_ok", inst_sram_data_ok, 0);
        check("arst_post_data_ok", data_sram_data_ok, 0);
        tick();
        settle();
        check("arst_post2_inst_ok", inst_sram_data_ok, 0);
        mem_data_ok   = 1'b0;
        inst_sram_req = 1'b1;
        settle();
        check("arst_first_grant", inst_sram_addr_ok, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: maximum outstanding accepted-but-unanswered mem transactions, power of 2, 2..16.
REQ-002 Parameter STARVE, default 4: consecutive data grants allowed while inst waits.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 inst_sram_req  in  1  IF read request.
REQ-006 inst_sram_addr  in  32  IF fetch address.
REQ-007 inst_sram_addr_ok  out  1  IF request accepted this cycle.
REQ-008 inst_sram_data_ok  out  1  IF read data valid this cycle.
REQ-009 inst_sram_rdata  out  32  IF read data.
REQ-010 data_sram_req  in  1  MEM-stage request.
REQ-011 data_sram_wr  in  1  1=write, 0=read.
REQ-012 data_sram_size  in  2  0=byte, 1=half, 2=word.
REQ-013 data_sram_wstrb  in  4  byte write enables.
REQ-014 data_sram_addr  in  32  data address.
REQ-015 data_sram_wdata  in  32  write data.
REQ-016 data_sram_addr_ok  out  1  data request accepted.
REQ-017 data_sram_data_ok  out  1  data response (read data or write done).
REQ-018 data_sram_rdata  out  32  data read data.
REQ-019 mem_req, mem_wr, mem_size[2], mem_wstrb[4], mem_addr[32], mem_wdata[32]  out  shared downstream request fields, same meaning as data_sram_*.
REQ-020 mem_addr_ok, mem_data_ok  in  1 each; mem_rdata  in  32  downstream handshake and read data.

Function
REQ-021 Inst port presented downstream SHALL use wr=0, size=2, wstrb=0, wdata=0.
REQ-022 Accept = mem_req & mem_addr_ok; response = mem_data_ok; downstream returns responses strictly in acceptance order.
REQ-023 Free-grant choice when unlocked: data if data_sram_req, else inst; exception: inst wins if inst_sram_req and starvation counter == STARVE.
REQ-024 Starvation counter: +1 on each data accept while inst_sram_req=1; cleared on inst accept or cycle with inst_sram_req=0; saturates at STARVE.
REQ-025 mem_req = (granted requester's req) & (count < DEPTH); all mem_* fields combinationally muxed from granted requester.
REQ-026 Lock: if mem_req=1 and mem_addr_ok=0, grant SHALL be held on same requester next cycle until accepted; mem_* fields stay stable while locked (requesters hold req/fields per sram-like rules).
REQ-027 <x>_sram_addr_ok = mem_addr_ok & mem_req & (grant==x); never asserted for both.
REQ-028 Owner FIFO, DEPTH entries, 1 bit (0=inst, 1=data): push owner on accept, pop on mem_data_ok.
REQ-029 Push and pop in same cycle: count unchanged, both pointers advance, wrap modulo DEPTH.
REQ-030 Full (count==DEPTH): mem_req=0, no addr_ok, even if pop occurs this cycle.
REQ-031 mem_data_ok while empty: ignored, no data_ok, count stays 0.
REQ-032 Response routing: <x>_sram_data_ok = mem_data_ok & (count>0) & (head owner==x), same cycle, zero latency; both rdata outputs = mem_rdata.
REQ-033 No cancellation; every accepted request receives exactly one data_ok.

Reset
REQ-034 resetn=0 SHALL immediately clear count, pointers, lock, starvation counter; mem_req, all addr_ok and data_ok SHALL read 0 while resetn=0.
REQ-035 After release, first grant on first cycle with a request; outstanding transactions at reset are discarded.

Verification
REQ-036 Both reqs high, mem_addr_ok=1 -> data granted, data_sram_addr_ok=1, inst_sram_addr_ok=0.
REQ-037 Data grant, mem_addr_ok=0 for 3 cycles, inst_req rises -> grant stays data, mem_addr constant until accept.
REQ-038 Continuous data+inst requests, mem_addr_ok=1 -> 4 data accepts then 1 inst accept, repeating.
REQ-039 Accept inst, data, inst; then 3 mem_data_ok with rdata 0x11,0x22,0x33 -> inst 0x11, data 0x22, inst 0x33.
REQ-040 4 accepts, no response -> mem_req=0; one mem_data_ok -> next cycle accept allowed; mem_data_ok when empty -> no data_ok.
REQ-041 resetn low with 2 outstanding -> outputs 0 asynchronously; after release, mem_data_ok ignored, count 0.
